// File: rtl/power_estimator_component.sv
// -----------------------------------------------------------------------------
// power_estimator_component
//
// Receive-side power estimator. It squares and sums the RX baseband I/Q
// samples in a three-stage pipeline, then averages the instantaneous power
// over a window of 2^LOG2_WIN accepted samples. Once per completed window it
// updates energy_out and pulses energy_valid for one cycle. These feed the
// threshold comparator's A input and en_comp enable.
//
// Ports
//   clk               in   sample clock, rising edge
//   rst               in   synchronous reset, active low
//   run_rx0           in   receiver running; low flushes the block to IDLE
//   threshold_changed in   one-cycle pulse; abandons the current window
//   strobe            in   I/Q sample valid qualifier
//   i_in, q_in        in   signed two's-complement I and Q samples
//   energy_out        out  floor of the mean power of the last completed window
//   energy_valid      out  one-cycle pulse when energy_out updates
//   busy              out  high while in ACCUM
// -----------------------------------------------------------------------------
module power_estimator_component #(
  parameter int WIDTH    = 16,
  parameter int LOG2_WIN = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run_rx0,
  input  logic                    threshold_changed,
  input  logic                    strobe,
  input  logic signed [WIDTH-1:0] i_in,
  input  logic signed [WIDTH-1:0] q_in,
  output logic [2*WIDTH-1:0]      energy_out,
  output logic                    energy_valid,
  output logic                    busy
);

  // Power word width. |x|^2 <= 2^30 for 16-bit x, so I^2+Q^2 <= 2^31 fits.
  localparam int PW    = 2 * WIDTH;
  // A full window of maximum-power samples cannot overflow this.
  localparam int ACC_W = PW + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_MAX = {LOG2_WIN{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   s1_v_q, s1_v_d;
  logic signed [WIDTH-1:0] i_q, i_d;
  logic signed [WIDTH-1:0] q_q, q_d;
  logic                   s2_v_q, s2_v_d;
  logic [PW-1:0]          ii_q, ii_d;
  logic [PW-1:0]          qq_q, qq_d;
  logic                   s3_v_q, s3_v_d;
  logic [PW-1:0]          p_q, p_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [LOG2_WIN-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]          energy_q, energy_d;
  logic                   ev_q, ev_d;
  logic                   busy_q, busy_d;

  logic signed [PW-1:0]   isq_s;
  logic signed [PW-1:0]   qsq_s;
  logic [ACC_W-1:0]       sum_s;

  // Squares and running sum; operands widened before multiplying so the
  // full signed product is kept.
  always_comb begin
    isq_s = PW'(i_q) * PW'(i_q);
    qsq_s = PW'(q_q) * PW'(q_q);
    sum_s = acc_q + ACC_W'(p_q);
  end

  // Next-state logic: FSM, pipeline stages, accumulator and window dump.
  always_comb begin
    state_d  = state_q;
    s1_v_d   = 1'b0;
    i_d      = i_q;
    q_d      = q_q;
    s2_v_d   = 1'b0;
    ii_d     = ii_q;
    qq_d     = qq_q;
    s3_v_d   = 1'b0;
    p_d      = p_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    energy_d = energy_q;
    ev_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Everything held clear; strobes are ignored on this edge even if
        // run_rx0 is rising.
        acc_d = {ACC_W{1'b0}};
        cnt_d = {LOG2_WIN{1'b0}};
        if (run_rx0) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCUM: begin
        if (!run_rx0) begin
          // Receiver stopped: drop the partial window and in-flight samples.
          state_d = ST_IDLE;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = {LOG2_WIN{1'b0}};
        end else if (threshold_changed) begin
          // Restart measurement. Any sample on this edge and any window that
          // would complete on this edge are discarded (valids stay 0, no dump).
          state_d = ST_ACCUM;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = {LOG2_WIN{1'b0}};
        end else begin
          state_d = ST_ACCUM;

          s1_v_d = strobe;
          if (strobe) begin
            i_d = i_in;
            q_d = q_in;
          end else begin
            i_d = i_q;
            q_d = q_q;
          end

          s2_v_d = s1_v_q;
          if (s1_v_q) begin
            ii_d = $unsigned(isq_s);
            qq_d = $unsigned(qsq_s);
          end else begin
            ii_d = ii_q;
            qq_d = qq_q;
          end

          s3_v_d = s2_v_q;
          if (s2_v_q) begin
            p_d = ii_q + qq_q;
          end else begin
            p_d = p_q;
          end

          if (s3_v_q) begin
            if (cnt_q == CNT_MAX) begin
              // Last sample of the window: publish floor(sum / 2^LOG2_WIN)
              // and start the next window on the very next sample.
              energy_d = sum_s[ACC_W-1:LOG2_WIN];
              ev_d     = 1'b1;
              acc_d    = {ACC_W{1'b0}};
              cnt_d    = {LOG2_WIN{1'b0}};
            end else begin
              acc_d = sum_s;
              cnt_d = cnt_q + LOG2_WIN'(1);
            end
          end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = {LOG2_WIN{1'b0}};
      end
    endcase

    busy_d = (state_d == ST_ACCUM);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      s1_v_q   <= 1'b0;
      i_q      <= {WIDTH{1'b0}};
      q_q      <= {WIDTH{1'b0}};
      s2_v_q   <= 1'b0;
      ii_q     <= {PW{1'b0}};
      qq_q     <= {PW{1'b0}};
      s3_v_q   <= 1'b0;
      p_q      <= {PW{1'b0}};
      acc_q    <= {ACC_W{1'b0}};
      cnt_q    <= {LOG2_WIN{1'b0}};
      energy_q <= {PW{1'b0}};
      ev_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_v_q   <= s1_v_d;
      i_q      <= i_d;
      q_q      <= q_d;
      s2_v_q   <= s2_v_d;
      ii_q     <= ii_d;
      qq_q     <= qq_d;
      s3_v_q   <= s3_v_d;
      p_q      <= p_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      energy_q <= energy_d;
      ev_q     <= ev_d;
      busy_q   <= busy_d;
    end
  end

  assign energy_out   = energy_q;
  assign energy_valid = ev_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_power_estimator_component.sv
// -----------------------------------------------------------------------------
// Testbench for power_estimator_component (WIDTH=16, LOG2_WIN=6).
// Each scenario task drives samples and, on the edge that captures the last
// sample of a window, pushes the expected mean power and the cycle in which
// energy_valid must be high. A negedge monitor pops and compares on every
// pulse and flags pulses that are unexpected or overdue.
// -----------------------------------------------------------------------------
module tb_power_estimator_component;

  logic               clk = 1'b0;
  logic               rst;
  logic               run_rx0;
  logic               threshold_changed;
  logic               strobe;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;
  logic [31:0]        energy_out;
  logic               energy_valid;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  power_estimator_component #(
    .WIDTH   (16),
    .LOG2_WIN(6)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .run_rx0          (run_rx0),
    .threshold_changed(threshold_changed),
    .strobe           (strobe),
    .i_in             (i_in),
    .q_in             (q_in),
    .energy_out       (energy_out),
    .energy_valid     (energy_valid),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge n settles, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (energy_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: energy_valid=1 at cycle %0d (energy_out=%0d), required no pulse",
                   cyc, energy_out);
        end else begin
          e = sb_q.pop_front();
          n_checks++;
          if (energy_out !== e.val) begin
            n_fail++;
            $display("FAIL pulse_value: energy_out=%0d, required %0d", energy_out, e.val);
          end
          n_checks++;
          if (cyc !== e.due) begin
            n_fail++;
            $display("FAIL pulse_timing: pulse at cycle %0d, required cycle %0d", cyc, e.due);
          end
        end
      end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
        e = sb_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_pulse: no energy_valid by cycle %0d, required at cycle %0d (value %0d)",
                 cyc, e.due, e.val);
      end
    end
  end

  // Apply one cycle of inputs, wait for the edge, then settle past it.
  task automatic drive(input logic r, input logic run, input logic thr, input logic stb,
                       input logic signed [15:0] i, input logic signed [15:0] q);
    rst               = r;
    run_rx0           = run;
    threshold_changed = thr;
    strobe            = stb;
    i_in              = i;
    q_in              = q;
    @(posedge clk);
    #1;
  endtask

  // Continuous strobes; the last one closes a window worth `val`.
  task automatic window(input int n, input logic signed [15:0] i, input logic signed [15:0] q,
                        input logic expect_pulse, input logic [31:0] val);
    for (int k = 1; k <= n; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, i, q);
      if (expect_pulse && k == n) sb_q.push_back('{val, cyc + 3});
    end
  endtask

  task automatic drain();
    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    n_checks++;
    if (energy_out !== 32'd0) begin
      n_fail++; $display("FAIL reset_energy_out: got %0d, required 0", energy_out);
    end
    n_checks++;
    if (energy_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_energy_valid: got %b, required 0", energy_valid);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_steady_tone();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_rise: got %b, required 1", busy);
    end
    window(64, 16'sd1000, 16'sd0, 1'b1, 32'd1000000);
    window(64, 16'sd1000, 16'sd0, 1'b1, 32'd1000000);
    drain();
    n_checks++;
    if (energy_out !== 32'd1000000) begin
      n_fail++; $display("FAIL tone_hold: energy_out=%0d, required 1000000", energy_out);
    end
  endtask

  task automatic test_full_scale();
    window(64, 16'sh8000, 16'sh8000, 1'b1, 32'h8000_0000);
    drain();
  endtask

  task automatic test_sparse();
    for (int k = 0; k < 64; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, (k % 2 == 0) ? 16'sd1 : 16'sd0, 16'sd0);
      if (k == 63) sb_q.push_back('{32'd0, cyc + 3});
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'sd5, 16'sd5);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'sd5, 16'sd5);
    end
    window(64, 16'sd3, 16'sd4, 1'b1, 32'd25);
    drain();
  endtask

  task automatic test_restart();
    // Window completes on the same edge as threshold_changed: discarded.
    window(64, 16'sd500, 16'sd0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'sd0, 16'sd0);
    n_checks++;
    if (energy_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_boundary_valid: got %b, required 0", energy_valid);
    end
    n_checks++;
    if (energy_out !== 32'd25) begin
      n_fail++; $display("FAIL restart_boundary_hold: energy_out=%0d, required 25", energy_out);
    end
    drain();
    // Partial window abandoned; the strobe on the restart edge is dropped.
    window(20, 16'sd1000, 16'sd0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'sd1000, 16'sd0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_busy: got %b, required 1", busy);
    end
    window(64, 16'sd2000, 16'sd0, 1'b1, 32'd4000000);
    drain();
  endtask

  task automatic test_rx_stop();
    window(30, 16'sd2000, 16'sd0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_busy: got %b, required 0", busy);
    end
    n_checks++;
    if (energy_out !== 32'd4000000) begin
      n_fail++; $display("FAIL stop_hold: energy_out=%0d, required 4000000", energy_out);
    end
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1, 16'sd2000, 16'sd0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b, required 0", busy);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rerun_busy: got %b, required 1", busy);
    end
    window(64, 16'sd100, 16'sd0, 1'b1, 32'd10000);
    drain();
  endtask

  task automatic test_reset_mid();
    window(40, 16'sd300, 16'sd0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sd300, 16'sd0);
    n_checks++;
    if (energy_out !== 32'd0) begin
      n_fail++; $display("FAIL midreset_energy_out: got %0d, required 0", energy_out);
    end
    n_checks++;
    if (energy_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_valid: got %b, required 0", energy_valid);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_busy: got %b, required 0", busy);
    end
    // Leaving IDLE: this strobe must be ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'sd7, 16'sd0);
    window(64, 16'sd300, 16'sd0, 1'b1, 32'd90000);
    drain();
  endtask

  initial begin
    rst               = 1'b0;
    run_rx0           = 1'b0;
    threshold_changed = 1'b0;
    strobe            = 1'b0;
    i_in              = 16'sd0;
    q_in              = 16'sd0;

    test_reset();
    test_steady_tone();
    test_full_scale();
    test_sparse();
    test_restart();
    test_rx_stop();
    test_reset_mid();

    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/power_estimator_component.md
# power_estimator_component

Receive-side power estimator feeding the spectrum-sensing threshold comparator. Consumes RX baseband I/Q samples, forms instantaneous power I²+Q² in a short pipeline, and averages it over a fixed power-of-two window. Once per window it presents a 32-bit mean power word plus a one-cycle strobe. These drive the comparator's `A` input and `en_comp` enable, so the transmit/hold decision is refreshed once per window.

## Interface
- `WIDTH`, 16: signed I/Q sample width; fixed at 16 for this block.
- `LOG2_WIN`, 6: log2 of the averaging window length in samples (window = 64); legal range 1..10.

- `clk`  in  1: sample clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `run_rx0`  in  1: receiver running. Low flushes the block to idle.
- `threshold_changed`  in  1: single-cycle pulse. Abandons the current window and restarts measurement.
- `strobe`  in  1: I/Q sample valid qualifier.
- `i_in`  in  16: signed two's-complement I sample.
- `q_in`  in  16: signed two's-complement Q sample.
- `energy_out`  out  32: unsigned mean power of the last completed window. Drives comparator `A`.
- `energy_valid`  out  1: one-cycle pulse when `energy_out` updates. Drives comparator `en_comp`.
- `busy`  out  1: high while a window is being accumulated (state ACCUM).

## Operation
- Per-sample power p = i_in·i_in + q_in·q_in, unsigned 32 bits; maximum 2^31 at (-32768, -32768), so no wrap.
- Accumulator width is 32+LOG2_WIN bits; it cannot overflow within one window.
- Output = accumulator sum >> LOG2_WIN, i.e. the floor of the mean. Result is always ≤ 2^31 and fits 32 bits.
- Three-stage datapath, each stage carrying a valid bit:
  - S1: register I, Q when `strobe`.
  - S2: register I², Q².
  - S3: register p.
  - Accumulate stage adds S3 p when S3 valid.
- Sample counter counts accumulated samples 0..2^LOG2_WIN-1. On the last sample (count = max and S3 valid):
  - `energy_out` <= (acc + p) >> LOG2_WIN;
  - `energy_valid` <= 1;
  - acc <= 0, count <= 0.
  - Next window begins immediately with no gap.
- FSM:
  - IDLE: acc, count and all stage valids held at 0. Go to ACCUM when `run_rx0`=1.
  - ACCUM: normal accumulation. Go to IDLE when `run_rx0`=0; partial window discarded, no `energy_valid`.
- `threshold_changed`=1 in ACCUM: clear acc, count and all stage valids on that edge. Stay in ACCUM.
  - A sample with `strobe` on the same edge is discarded.
  - A window completing on that same edge is also discarded: no `energy_valid`, `energy_out` unchanged.
- `energy_out` holds its last value through IDLE and restarts. Only a completed window or reset changes it.
- `strobe` in IDLE is ignored. `strobe` may be any duty cycle; a gap simply stalls the window.

## Timing
- Reset (`rst`=0 at an edge) forces:
  - `energy_out`=0, `energy_valid`=0, `busy`=0;
  - state IDLE; acc, count and valids 0.
  - Reset mid-window aborts it with no output.
- Latency: `energy_valid` is high during the 4th cycle after the edge that captured the window's last strobed sample. That sample's power is included in the output.
- `energy_valid` is exactly one cycle wide. `energy_out` is stable from that cycle until the next pulse.
- Minimum pulse spacing is 2^LOG2_WIN cycles (strobe continuously high).
- `busy` rises the cycle after `run_rx0` is sampled high and falls the cycle after it is sampled low.
- Priority when several events coincide on one edge, highest first: reset, then `run_rx0`=0, then `threshold_changed`, then normal accumulate/dump.

## Test plan
- **Steady tone:** reset, `run_rx0`=1, I=1000, Q=0, `strobe` always high, LOG2_WIN=6.
  - `energy_valid` first high 4 cycles after the 64th sample edge, then every 64 cycles.
  - `energy_out`=1_000_000.
- **Full scale:** I=Q=-32768 for 64 samples -> `energy_out`=0x8000_0000; no wrap.
- **Truncation and sparse strobe:**
  - I alternating 1/0, Q=0, `strobe` every 3rd cycle -> mean 0.5 floors to `energy_out`=0; one pulse per 64 strobes (192 cycles).
  - I=3, Q=4 -> `energy_out`=25.
- **Restart:** 20 samples of I=1000, then a `threshold_changed` pulse, then 64 samples of I=2000 -> first pulse reports 4_000_000. No pulse from the aborted window.
- **Receiver stop:**
  - Drop `run_rx0` after 30 samples -> `busy`=0 next cycle, no pulse, `energy_out` retains its previous value.
  - Re-raise `run_rx0` -> a fresh 64-sample window is required before the next pulse.
- **Reset mid-operation:** `rst`=0 for one edge at sample 40 -> `energy_out`=0 and `energy_valid`=0 on the following cycle. With `run_rx0` still high, the next pulse arrives only after a full new window.
